pc_counter: RTL and testbench
=============================

Name: pc_counter

Overview:
- Registered program-counter stage that sits directly downstream of the 8-bit incrementer.
- Holds the current count Q and advances it by one (Q+1, modulo 2^WIDTH) each enabled cycle.
- Supports a parallel load (jump), a halt/single-step control state machine, and a registered one-cycle wrap flag.
- Feeds the address/sequence input of the next stage.

Parameters:
WIDTH, 8, data width of D and Q.
RESET_VALUE, 0, value loaded into Q on reset.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  increment enable (RUN state only).
LD  input  1  parallel load request; priority over EN.
D  input  WIDTH  load value.
HALT_REQ  input  1  level request to stop counting.
STEP  input  1  single-step request, sampled in HALT.
Q  output  WIDTH  current count, registered.
WRAP  output  1  registered pulse: Q rolled from all-ones to zero this cycle.
HALTED  output  1  registered: 1 while in HALT state.

Behaviour:
- Interface: one clock (CLK); reset (RST) is synchronous and active-high.
- Reset (RST=1 at rising edge):
  - Q=RESET_VALUE, WRAP=0, HALTED=0, state=RUN.
  - RST overrides all other inputs, including mid-step.
- All outputs are registered; every update is visible the cycle after the inputs are sampled.
- States: RUN, HALT, STEP.
- RUN:
  - LD=1: Q<=D, WRAP<=0.
  - Else EN=1: Q<=Q+1 (truncated to WIDTH); WRAP<=1 only if Q was all-ones, else 0.
  - Else: Q held, WRAP<=0.
  - HALT_REQ=1: next state HALT, HALTED<=1. An LD/EN update sampled in the same cycle still takes effect (halt is non-destructive, one cycle of latency).
- HALT:
  - Q held, WRAP<=0, EN ignored.
  - LD=1: Q<=D (debug write); state stays HALT.
  - Else STEP=1: next state STEP.
  - Else HALT_REQ=0: next state RUN, HALTED<=0.
  - Priority: LD > STEP > resume.
- STEP (exactly one cycle):
  - Q<=Q+1 unconditionally (EN ignored); WRAP follows the RUN rule.
  - Next state HALT; HALTED stays 1 throughout.
  - LD in this cycle is ignored.
  - STEP held high re-enters STEP every other cycle: HALT, STEP, HALT, STEP, ...
- Arithmetic:
  - Unsigned, modulo 2^WIDTH; carry beyond WIDTH is discarded except as WRAP.
  - A load of all-ones never asserts WRAP; only the following increment does.
- The transition from HALT to RUN takes effect the cycle after HALT_REQ drops. EN sampled on the resume cycle is ignored.
- X/Z handling on inputs is not required.

Test Plan:
- Reset then count: RST=1 for 2 cycles, then EN=1 for 10 cycles -> Q=0 during reset, then 1,2,...,10; WRAP=0; HALTED=0.
- Wrap: LD=1 with D=8'hFE, then EN=1 for 3 cycles -> Q=FE, FF, 00, 01; WRAP=1 only in the cycle Q=00.
- Load priority: LD=1, EN=1, D=8'h40 -> Q=40 (not 41); next cycle with EN only -> Q=41.
- Halt and step: Q=10 with EN=1; assert HALT_REQ -> Q=11 and HALTED=1 on the same edge, then Q holds at 11 with EN=1. STEP pulse for 1 cycle -> Q=12 one cycle later, HALTED stays 1. Drop HALT_REQ -> HALTED=0 next cycle, counting resumes at 13 on the following cycle.
- Debug load in HALT: while halted, LD=1 with D=8'h80 and STEP=1 -> Q=80, state HALT, no increment; next STEP -> Q=81.
- Reset mid-step: RST=1 in the STEP cycle -> Q=00, HALTED=0, state RUN on the next edge.

Source files
------------

// File: rtl/pc_counter.sv
// Registered program-counter stage: increments, parallel loads and supports
// halt/single-step control with a registered one-cycle wrap flag.
module pc_counter #(
  parameter int unsigned            WIDTH       = 8,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             HALT_REQ,
  input  logic             STEP,
  output logic [WIDTH-1:0] Q,
  output logic             WRAP,
  output logic             HALTED
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   q_next;
  logic               wrap_next;
  logic [WIDTH:0]     inc_sum;

  // Incrementer with the carry kept; the carry is the wrap indication.
  always_comb begin
    inc_sum = {1'b0, Q} + (WIDTH+1)'(1);
  end

  // Next-state, next-count and next-wrap decode.
  always_comb begin
    state_next = state;
    q_next     = Q;
    wrap_next  = 1'b0;
    case (state)
      S_RUN: begin
        if (LD) begin
          q_next = D;
        end else if (EN) begin
          q_next    = inc_sum[WIDTH-1:0];
          wrap_next = inc_sum[WIDTH];
        end
        // The update above still lands on the halting edge.
        if (HALT_REQ) begin
          state_next = S_HALT;
        end
      end
      S_HALT: begin
        if (LD) begin
          q_next = D;
        end else if (STEP) begin
          state_next = S_STEP;
        end else if (!HALT_REQ) begin
          state_next = S_RUN;
        end
      end
      S_STEP: begin
        q_next     = inc_sum[WIDTH-1:0];
        wrap_next  = inc_sum[WIDTH];
        state_next = S_HALT;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_RUN;
      Q      <= RESET_VALUE;
      WRAP   <= 1'b0;
      HALTED <= 1'b0;
    end else begin
      state  <= state_next;
      Q      <= q_next;
      WRAP   <= wrap_next;
      HALTED <= (state_next != S_RUN);
    end
  end

endmodule

// File: tb/tb_pc_counter.sv
// Self-checking bench for pc_counter: directed vector table, a short
// hand-written sequence, then randomized stimulus against a behavioural model.
module tb_pc_counter;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         EN = 1'b0;
  logic         LD = 1'b0;
  logic [W-1:0] D = '0;
  logic         HALT_REQ = 1'b0;
  logic         STEP = 1'b0;
  logic [W-1:0] Q;
  logic         WRAP;
  logic         HALTED;

  int checks = 0;
  int failures = 0;

  pc_counter #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .LD(LD), .D(D),
    .HALT_REQ(HALT_REQ), .STEP(STEP), .Q(Q), .WRAP(WRAP), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit       rst, en, ld;
    bit [7:0] d;
    bit       hr, st;
    bit [7:0] eq;
    bit       ew, eh;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit en, bit ld, bit [7:0] d, bit hr, bit st,
                              bit [7:0] eq, bit ew, bit eh);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.d = d; v.hr = hr; v.st = st;
    v.eq = eq; v.ew = ew; v.eh = eh;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, sample just after the edge.
  task automatic cycle(input bit rst, input bit en, input bit ld, input bit [7:0] d,
                       input bit hr, input bit st);
    RST = rst; EN = en; LD = ld; D = d; HALT_REQ = hr; STEP = st;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect3(input string name, input bit [7:0] eq, input bit ew, input bit eh);
    check({name, ".Q"}, int'(Q), int'(eq));
    check({name, ".WRAP"}, int'(WRAP), int'(ew));
    check({name, ".HALTED"}, int'(HALTED), int'(eh));
  endtask

  // Behavioural model: mode 0 = running, 1 = halted, 2 = single step pending.
  int m_q, m_mode;
  bit m_wrap;

  task automatic model_step(input bit rst, input bit en, input bit ld, input int d,
                            input bit hr, input bit st);
    int nq, nmode;
    bit nwrap;
    nq = m_q; nmode = m_mode; nwrap = 0;
    if (rst) begin
      nq = 0; nmode = 0;
    end else if (m_mode == 0) begin
      if (ld) nq = d;
      else if (en) begin nq = (m_q + 1) % 256; nwrap = (m_q == 255); end
      if (hr) nmode = 1;
    end else if (m_mode == 1) begin
      if (ld) nq = d;
      else if (st) nmode = 2;
      else if (!hr) nmode = 0;
    end else begin
      nq = (m_q + 1) % 256; nwrap = (m_q == 255); nmode = 1;
    end
    m_q = nq; m_mode = nmode; m_wrap = nwrap;
  endtask

  initial begin
    // rst en ld d hr st | q wrap halted
    add(1,0,0,8'h00,0,0, 8'h00,0,0);
    add(1,1,0,8'h00,0,0, 8'h00,0,0);
    for (int i = 1; i <= 10; i++) add(0,1,0,8'h00,0,0, 8'(i),0,0);
    add(0,0,1,8'hFE,0,0, 8'hFE,0,0);
    add(0,1,0,8'h00,0,0, 8'hFF,0,0);
    add(0,1,0,8'h00,0,0, 8'h00,1,0);
    add(0,1,0,8'h00,0,0, 8'h01,0,0);
    add(0,1,1,8'h40,0,0, 8'h40,0,0);
    add(0,1,0,8'h00,0,0, 8'h41,0,0);
    add(0,0,1,8'h10,0,0, 8'h10,0,0);
    add(0,1,0,8'h00,1,0, 8'h11,0,1);
    add(0,1,0,8'h00,1,0, 8'h11,0,1);
    add(0,1,0,8'h00,1,1, 8'h11,0,1);
    add(0,1,0,8'h00,1,0, 8'h12,0,1);
    add(0,1,0,8'h00,0,0, 8'h12,0,0);
    add(0,1,0,8'h00,0,0, 8'h13,0,0);
    add(0,1,0,8'h00,1,0, 8'h14,0,1);
    add(0,0,1,8'h80,1,1, 8'h80,0,1);
    add(0,0,0,8'h00,1,1, 8'h80,0,1);
    add(0,0,0,8'h00,1,1, 8'h81,0,1);
    add(0,0,0,8'h00,1,1, 8'h81,0,1);
    add(0,0,1,8'h05,1,0, 8'h82,0,1);
    add(0,0,1,8'hFF,1,0, 8'hFF,0,1);
    add(0,0,0,8'h00,1,1, 8'hFF,0,1);
    add(0,0,0,8'h00,1,0, 8'h00,1,1);
    add(0,0,0,8'h00,1,1, 8'h00,0,1);
    add(1,1,0,8'h00,1,0, 8'h00,0,0);
    add(0,1,0,8'h00,0,0, 8'h01,0,0);
    add(0,0,1,8'hFF,0,0, 8'hFF,0,0);
    add(0,1,0,8'h00,0,0, 8'h00,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].d, vecs[i].hr, vecs[i].st);
      expect3($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ew, vecs[i].eh);
    end

    // Step requested while HALT_REQ already dropped; step wins over resume.
    cycle(0,0,1,8'h20,1,0); expect3("seq_halt", 8'h20, 0, 1);
    cycle(0,1,0,8'h00,0,1); expect3("seq_go_step", 8'h20, 0, 1);
    cycle(0,1,0,8'h00,0,0); expect3("seq_step", 8'h21, 0, 1);
    cycle(0,1,0,8'h00,0,0); expect3("seq_resume", 8'h21, 0, 0);
    cycle(0,1,0,8'h00,0,0); expect3("seq_run", 8'h22, 0, 0);

    // Randomized phase, model starts from the known state above.
    m_q = 8'h22; m_mode = 0; m_wrap = 0;
    begin
      bit hr;
      hr = 0;
      for (int n = 0; n < 600; n++) begin
        bit rst, en, ld, st;
        bit [7:0] d;
        rst = ($urandom_range(99) < 3);
        en  = ($urandom_range(99) < 70);
        ld  = ($urandom_range(99) < 12);
        st  = ($urandom_range(99) < 35);
        d   = ($urandom_range(3) == 0) ? 8'hFF - 8'($urandom_range(2)) : 8'($urandom);
        if ($urandom_range(99) < 15) hr = ~hr;
        cycle(rst, en, ld, d, hr, st);
        model_step(rst, en, ld, int'(d), hr, st);
        expect3($sformatf("rnd%0d", n), 8'(m_q), m_wrap, (m_mode != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
